alu_shift_unit: RTL
===================

// Module: alu_shift_unit
// PURPOSE
//  Parametrised multi-cycle shift/rotate unit for the core ALU; replaces the purely
//  combinational/registered shifter path. Accepts one op via valid/ready, computes it
//  (single-cycle barrel or iterative 4/1-bit stepping), holds result until consumed.
//  Sits between operand select (reg_op1/reg_op2) and the writeback mux.
// PARAMETERS
//  XLEN            32  datapath width (power of 2, >=8); SHW = $clog2(XLEN)
//  BARREL_SHIFTER  0   1: full shift in one step; 0: iterative stepping
//  TWO_STAGE_SHIFT 1   iterative only: step by 4 while cnt>=4, else by 1; 0: always by 1
//  ENABLE_ROTATE   1   1: op 2'b11 = rotate right; 0: op 2'b11 executes as SRL
// PORTS
//  clk        in   1     clock, all state on posedge
//  reset      in   1     synchronous, active-high
//  flush      in   1     synchronous abort of any in-flight/held op
//  in_valid   in   1     op request
//  in_ready   out  1     unit can accept op this cycle
//  in_op      in   2     00 SLL, 01 SRL, 10 SRA, 11 ROR
//  in_data    in   XLEN  operand
//  in_shamt   in   SHW   shift amount (only SHW bits exist; no overflow case)
//  out_valid  out  1     result valid
//  out_ready  in   1     consumer takes result
//  out_data   out  XLEN  result
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, out_valid=0, out_data=0, busy=0, cnt=0; in_ready=1 next cycle.
//  - States IDLE, SHIFT, DONE. Accept = in_valid & in_ready at posedge.
//  - in_ready = ~flush & (state==IDLE | (state==DONE & out_ready)) (back-to-back).
//  - On accept: latch op, data, cnt=shamt. Barrel or shamt==0 -> DONE with result
//    (barrel result computed from inputs in same cycle). Else -> SHIFT.
//  - SHIFT, per cycle: k = (TWO_STAGE_SHIFT & cnt>=4) ? 4 : 1; data shifted by k
//    per op; cnt -= k; if new cnt==0 -> DONE. No input accepted in SHIFT.
//  - Latency (accept edge to out_valid high): 1 + steps; steps = 0 (barrel or shamt 0),
//    shamt>>2 + shamt[1:0] (two-stage), shamt (single-step).
//  - SLL/SRL zero-fill; SRA fills with latched data[XLEN-1] each step; ROR wraps LSBs
//    to MSBs; result identical to one-shot op for all shamt 0..XLEN-1.
//  - DONE: out_valid=1, out_data stable until out_ready; out_ready&~accept -> IDLE;
//    out_ready&accept -> new op loaded same edge (out_valid drops unless next is 1-cycle).
//  - out_valid asserted only in DONE; out_data holds last result after consumption.
//  - flush (any state): next state IDLE, out_valid=0, no accept that cycle; result lost.
//  - flush and reset same cycle: reset wins (identical effect plus out_data=0).
//  - reset mid-SHIFT/DONE: op discarded, no out_valid ever produced for it.
//  - in_op/in_data/in_shamt sampled only on accept; changes afterwards ignored.
// TESTING
//  - XLEN=32 two-stage: SRA 0x80000000 shamt 31 -> 0xFFFFFFFF, out_valid 11 cycles after accept (7x4+3x1).
//  - SLL 0x00000001 shamt 0 -> 0x00000001, latency 1; SLL shamt 5 -> 0x00000020, latency 3.
//  - ROR 0x12345678 shamt 8 -> 0x78123456 latency 3; ENABLE_ROTATE=0 same op -> 0x00123456.
//  - out_ready low 4 cycles in DONE -> out_data stable, in_ready=0; then out_ready=1 with in_valid -> next op accepted same edge.
//  - flush when cnt=5 -> IDLE next cycle, no out_valid; next SRL 0xF0 shamt 4 -> 0x0F.
//  - XLEN=64 BARREL_SHIFTER=1: SRL 0x8000_0000_0000_0000 shamt 63 -> 1, latency 1, one op per cycle streaming; reset mid-stream -> out_valid=0, out_data=0.

Source files
------------

// File: rtl/alu_shift_unit.sv
// Shift/rotate unit for the core ALU: accepts one op via valid/ready, computes it either
// in one barrel step or by iterative 4/1-bit stepping, and holds the result until consumed.
module alu_shift_unit #(
  parameter int XLEN            = 32,
  parameter int BARREL_SHIFTER  = 0,
  parameter int TWO_STAGE_SHIFT = 1,
  parameter int ENABLE_ROTATE   = 1,
  localparam int SHW            = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_data,
  input  logic [SHW-1:0]  in_shamt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [1:0]     OP_SLL   = 2'b00;
  localparam logic [1:0]     OP_SRL   = 2'b01;
  localparam logic [1:0]     OP_SRA   = 2'b10;
  localparam logic [1:0]     OP_ROR   = 2'b11;
  localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1'b1);
  localparam logic [SHW-1:0] CNT_FOUR = SHW'(3'd4);
  localparam logic [SHW:0]   XLEN_W   = (SHW+1)'(XLEN);
  localparam bit             USE_BARREL = (BARREL_SHIFTER != 32'sd0);
  localparam bit             USE_FOUR   = (TWO_STAGE_SHIFT != 32'sd0);
  localparam bit             USE_ROT    = (ENABLE_ROTATE != 32'sd0);

  // One-shot shift by an arbitrary amount; rotate is the OR of the two complementary shifts.
  function automatic logic [XLEN-1:0] shift_full(input logic [1:0] op,
                                                 input logic [XLEN-1:0] d,
                                                 input logic [SHW-1:0] amt);
    logic [SHW:0] lamt;
    lamt = XLEN_W - {1'b0, amt};
    case (op)
      OP_SLL:  shift_full = d << amt;
      OP_SRL:  shift_full = d >> amt;
      OP_SRA:  shift_full = $unsigned($signed(d) >>> amt);
      OP_ROR:  shift_full = (d >> amt) | (d << lamt);
      default: shift_full = d;
    endcase
  endfunction

  // Fixed-distance step of 4 or 1 bits; SRA replicates the sign bit, which never changes.
  function automatic logic [XLEN-1:0] shift_step(input logic [1:0] op,
                                                 input logic [XLEN-1:0] d,
                                                 input logic four);
    case (op)
      OP_SLL:  shift_step = four ? {d[XLEN-5:0], 4'b0000} : {d[XLEN-2:0], 1'b0};
      OP_SRL:  shift_step = four ? {4'b0000, d[XLEN-1:4]} : {1'b0, d[XLEN-1:1]};
      OP_SRA:  shift_step = four ? {{4{d[XLEN-1]}}, d[XLEN-1:4]} : {d[XLEN-1], d[XLEN-1:1]};
      OP_ROR:  shift_step = four ? {d[3:0], d[XLEN-1:4]} : {d[0], d[XLEN-1:1]};
      default: shift_step = d;
    endcase
  endfunction

  state_t          state_r, state_s;
  logic [1:0]      op_r, op_s, eff_op_s;
  logic [XLEN-1:0] data_r, data_s, step_data_s;
  logic [SHW-1:0]  cnt_r, cnt_s, step_k_s, cnt_dec_s;
  logic [XLEN-1:0] out_data_r, out_data_s;
  logic            out_valid_r, busy_r;
  logic            in_ready_s, accept_s, step_four_s;

  // Acceptance, step sizing and next-state / next-datapath selection.
  always_comb begin
    state_s     = state_r;
    op_s        = op_r;
    data_s      = data_r;
    cnt_s       = cnt_r;
    out_data_s  = out_data_r;
    in_ready_s  = ~flush & ((state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready));
    accept_s    = in_valid & in_ready_s;
    eff_op_s    = (!USE_ROT && (in_op == OP_ROR)) ? OP_SRL : in_op;
    step_four_s = USE_FOUR && (cnt_r >= CNT_FOUR);
    step_k_s    = step_four_s ? CNT_FOUR : CNT_ONE;
    step_data_s = shift_step(op_r, data_r, step_four_s);
    cnt_dec_s   = cnt_r - step_k_s;

    if (flush) begin
      state_s = ST_IDLE;
      cnt_s   = CNT_ZERO;
    end else if (accept_s) begin
      op_s   = eff_op_s;
      data_s = in_data;
      if (USE_BARREL || (in_shamt == CNT_ZERO)) begin
        state_s    = ST_DONE;
        cnt_s      = CNT_ZERO;
        out_data_s = USE_BARREL ? shift_full(eff_op_s, in_data, in_shamt) : in_data;
      end else begin
        state_s = ST_SHIFT;
        cnt_s   = in_shamt;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        ST_SHIFT: begin
          data_s = step_data_s;
          cnt_s  = cnt_dec_s;
          if (cnt_dec_s == CNT_ZERO) begin
            state_s    = ST_DONE;
            out_data_s = step_data_s;
          end else begin
            state_s = ST_SHIFT;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, datapath and registered status outputs; reset also clears the held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_SLL;
      data_r      <= {XLEN{1'b0}};
      cnt_r       <= CNT_ZERO;
      out_data_r  <= {XLEN{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      op_r        <= op_s;
      data_r      <= data_s;
      cnt_r       <= cnt_s;
      out_data_r  <= out_data_s;
      out_valid_r <= (state_s == ST_DONE);
      busy_r      <= (state_s != ST_IDLE);
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

endmodule
